// File: rtl/jtag_cmd_arbiter.sv
// Round-robin arbiter that shares the JTAG engine and its instruction/data FIFOs between NUM_REQ sources.
// Optional busy watchdog enabled by defining JTAG_ARB_TIMEOUT_EN.
module jtag_cmd_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int DATA_INSTRUCTION = 6,
    parameter int DATA_FIFO        = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int LEN_W            = $clog2(FIFO_DEPTH) + 1,
    parameter int TIMEOUT_CYC      = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*DATA_INSTRUCTION-1:0] req_instr,
    input  logic [NUM_REQ-1:0]                  req_op,
    input  logic [NUM_REQ*LEN_W-1:0]            req_len,
    input  logic [NUM_REQ*DATA_FIFO-1:0]        data_in,
    input  logic [NUM_REQ-1:0]                  data_valid,
    output logic [NUM_REQ-1:0]                  data_ready,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  done,
    output logic                                err,
    output logic [DATA_INSTRUCTION-1:0]         wdata_instruction,
    output logic                                wr_instruction,
    input  logic                                full_instruction,
    output logic [DATA_FIFO-1:0]                wdata_data,
    output logic                                wr_data,
    input  logic                                full_data,
    output logic                                work,
    output logic                                op,
    input  logic                                busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_DATA,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            last;
    logic [IDX_W-1:0]            g_idx;
    logic [IDX_W-1:0]            win_idx;
    logic [IDX_W-1:0]            scan_idx;
    logic                        win_found;
    logic [LEN_W-1:0]            len_sel;
    logic [DATA_INSTRUCTION-1:0] instr_q;
    logic                        op_q;
    logic                        err_q;
    logic [LEN_W-1:0]            remaining;
    logic                        tmo_hit;

    // Search starts just after the last served requester, so priority rotates.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign len_sel = req_len[win_idx*LEN_W +: LEN_W];

    assign data_ready        = (state == S_DATA && !full_data && remaining != '0) ? gnt : '0;
    assign wr_data           = |(data_valid & data_ready);
    assign wdata_data        = data_in[g_idx*DATA_FIFO +: DATA_FIFO];
    assign wdata_instruction = instr_q;

`ifdef JTAG_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // WAIT_BUSY is only ever entered from START, so clearing there clears on entry.
    always_ff @(posedge clk) begin
        if (rst || state == S_START) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT_BUSY || state == S_RUN) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            last           <= IDX_W'(NUM_REQ - 1);
            g_idx          <= '0;
            gnt            <= '0;
            done           <= '0;
            err            <= 1'b0;
            wr_instruction <= 1'b0;
            work           <= 1'b0;
            op             <= 1'b0;
            instr_q        <= '0;
            op_q           <= 1'b0;
            err_q          <= 1'b0;
            remaining      <= '0;
        end else begin
            done           <= '0;
            err            <= 1'b0;
            wr_instruction <= 1'b0;
            work           <= 1'b0;
            op             <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (win_found) begin
                        g_idx     <= win_idx;
                        gnt       <= NUM_REQ'(1) << win_idx;
                        instr_q   <= req_instr[win_idx*DATA_INSTRUCTION +: DATA_INSTRUCTION];
                        op_q      <= req_op[win_idx];
                        remaining <= len_sel;
                        err_q     <= (len_sel > LEN_W'(FIFO_DEPTH));
                        state     <= (len_sel > LEN_W'(FIFO_DEPTH)) ? S_DONE : S_INSTR;
                    end
                end
                S_INSTR: begin
                    if (!full_instruction) begin
                        wr_instruction <= 1'b1;
                        state          <= (remaining != '0) ? S_DATA : S_START;
                    end
                end
                S_DATA: begin
                    if (wr_data) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    work  <= 1'b1;
                    op    <= op_q;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (busy) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (!busy) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= gnt;
                    err   <= err_q;
                    gnt   <= '0;
                    last  <= g_idx;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtag_cmd_arbiter.md
Name: jtag_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the JTAG engine and its instruction/data FIFOs between NUM_REQ command sources.
- Grants one requester at a time and holds the grant for the whole transaction: push instruction, stream data words, pulse work/op, track engine busy, report done.
- Sits between command sources (jtag_fsm-style producers) and the instruction FIFO, data FIFO and jtag engine control inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_INSTRUCTION, 6, instruction word width.
- DATA_FIFO, 8, data word width.
- FIFO_DEPTH, 16, depth of both FIFOs; maximum legal len.
- LEN_W, $clog2(FIFO_DEPTH)+1, width of per-requester length field.
- TIMEOUT_CYC, 1024, busy watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester command request, level.
- req_instr  in  NUM_REQ*DATA_INSTRUCTION  flattened instruction per requester; slot i at [i*DATA_INSTRUCTION +: DATA_INSTRUCTION].
- req_op  in  NUM_REQ  operation bit per requester.
- req_len  in  NUM_REQ*LEN_W  data word count per requester.
- data_in  in  NUM_REQ*DATA_FIFO  flattened data words.
- data_valid  in  NUM_REQ  data word valid.
- data_ready  out  NUM_REQ  data word accepted this cycle when valid&ready.
- gnt  out  NUM_REQ  one-hot grant.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  qualifies done: command rejected or aborted.
- wdata_instruction  out  DATA_INSTRUCTION  to instruction FIFO.
- wr_instruction  out  1  instruction FIFO write strobe.
- full_instruction  in  1  instruction FIFO full.
- wdata_data  out  DATA_FIFO  to data FIFO.
- wr_data  out  1  data FIFO write strobe.
- full_data  in  1  data FIFO full.
- work  out  1  one-cycle start pulse to the engine.
- op  out  1  operation, valid while work=1.
- busy  in  1  engine busy.

Behaviour:
- Reset: state IDLE; gnt, done, err, wr_instruction, wr_data, work, op, data_ready all 0. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - Scan req from last+1 with wrap; first set bit wins.
  - Register gnt and capture instr, op, len of the winner.
  - If captured len>FIFO_DEPTH, go to DONE with err=1 and no FIFO writes; otherwise go to INSTR.
- INSTR:
  - When full_instruction=0, assert wr_instruction for exactly one cycle with the captured instr.
  - Then go to DATA if len>0, else START.
- DATA:
  - data_ready[g]=1 only while in DATA, full_data=0 and remaining>0; other data_ready bits stay 0.
  - wr_data = data_valid[g] & data_ready[g], same cycle (combinational); wdata_data = data_in slot g.
  - remaining decrements per write; after the write that makes it 0, go to START.
  - full_data stalls the stream with no word loss.
- START: work=1, op=captured op, one cycle; then WAIT_BUSY.
- WAIT_BUSY: wait for busy=1, then RUN.
- RUN: wait for busy=0, then DONE.
- DONE:
  - done[g]=1 and err for one cycle; last=g; gnt cleared.
  - Return to IDLE; earliest re-arbitration is the next cycle.
- Grant is held to DONE; deasserting req mid-transaction is ignored. Captured fields are frozen at grant.
- Simultaneous requests are resolved purely by round-robin; a lone requester can be re-granted back-to-back.
- Reset mid-transaction: immediate return to IDLE with reset values. Partial FIFO contents are the FIFOs' concern; they share rst.
- Minimum transaction with len=0 and busy high for 1 cycle: grant to done = 6 cycles.

Optional Feature:
- JTAG_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT_BUSY and RUN.
  - Reaching TIMEOUT_CYC forces DONE with err=1.
  - The counter clears on entry to WAIT_BUSY.
- Undefined:
  - No counter; the arbiter waits on busy indefinitely.
  - err is set only by len>FIFO_DEPTH.

Test Plan:
- Single command: req[0], instr=6'h2A, op=1, len=3, data 8'h11/22/33, busy high 4 cycles -> one wr_instruction with 6'h2A; wr_data 11,22,33 in order; one work pulse with op=1; done[0] with err=0.
- Contention: req=2'b11 held -> grants alternate 0,1,0,1; no overlapping gnt; each done precedes the next gnt.
- Backpressure: full_data high for 5 cycles mid-stream of len=4 -> data_ready[g]=0 during stall; exactly 4 writes, no duplicates.
- Illegal length: len=17 with FIFO_DEPTH=16 -> no FIFO writes, no work; done with err=1 on the cycle after grant.
- Reset mid-op: rst in DATA after 2 of 4 words -> all outputs 0 next cycle; next grant goes to requester 0.
- Timeout (JTAG_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): busy never rises -> done with err=1 eight cycles after WAIT_BUSY entry.
